game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_game_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game sequencing controller for a paddle-and-ball game: owns lives, level and
// the game state, and turns button levels into paddle step and serve pulses.
module game_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int MOVE_DIV   = 50000,
    parameter int MISS_HOLD  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       ball_missed,
    input  logic       bricks_cleared,
    output logic       board_rst,
    output logic       board_pause,
    output logic       move_left,
    output logic       move_right,
    output logic       ball_launch,
    output logic [2:0] lives,
    output logic [3:0] level,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_PAUSED = 3'd3,
        S_MISS   = 3'd4,
        S_OVER   = 3'd5
    } state_t;

    localparam logic [19:0] MOVE_LAST  = 20'(MOVE_DIV - 1);
    localparam logic [25:0] MISS_LAST  = 26'(MISS_HOLD - 1);
    localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_INIT);

    state_t      r_state;
    state_t      r_saved;
    logic        r_start_prev;
    logic        r_pause_prev;
    logic [2:0]  r_lives;
    logic [3:0]  r_level;
    logic [19:0] r_move_cnt;
    logic [25:0] r_miss_cnt;
    logic        r_board_rst;
    logic        r_board_pause;
    logic        r_ball_launch;
    logic        r_move_left;
    logic        r_move_right;

    logic w_start_edge;
    logic w_pause_edge;
    logic w_hold_active;
    logic w_tick;

    assign w_start_edge = btn_start & ~r_start_prev;
    assign w_pause_edge = btn_pause & ~r_pause_prev;
    assign w_tick       = (r_move_cnt == MOVE_LAST);

    // True when this edge keeps the paddle live in SERVE/PLAY without leaving
    // or re-entering SERVE; the move counter only advances (and ticks) then.
    assign w_hold_active = ((r_state == S_SERVE) && !w_pause_edge) ||
                           ((r_state == S_PLAY) && !ball_missed &&
                            !bricks_cleared && !w_pause_edge);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_saved       <= S_SERVE;
            r_start_prev  <= 1'b0;
            r_pause_prev  <= 1'b0;
            r_lives       <= 3'd0;
            r_level       <= 4'd0;
            r_move_cnt    <= 20'd0;
            r_miss_cnt    <= 26'd0;
            r_board_rst   <= 1'b0;
            r_board_pause <= 1'b1;
            r_ball_launch <= 1'b0;
            r_move_left   <= 1'b0;
            r_move_right  <= 1'b0;
        end else begin
            r_start_prev  <= btn_start;
            r_pause_prev  <= btn_pause;
            r_board_rst   <= 1'b0;
            r_ball_launch <= 1'b0;
            r_move_left   <= w_hold_active & w_tick & btn_left & ~btn_right;
            r_move_right  <= w_hold_active & w_tick & btn_right & ~btn_left;

            if (w_hold_active) begin
                r_move_cnt <= w_tick ? 20'd0 : r_move_cnt + 20'd1;
            end else begin
                r_move_cnt <= 20'd0;
            end

            case (r_state)
                S_IDLE, S_OVER: begin
                    if (w_start_edge) begin
                        r_state       <= S_SERVE;
                        r_lives       <= LIVES_LOAD;
                        r_level       <= 4'd1;
                        r_board_rst   <= 1'b1;
                        r_board_pause <= 1'b0;
                    end
                end

                S_SERVE: begin
                    if (w_pause_edge) begin
                        r_saved       <= S_SERVE;
                        r_state       <= S_PAUSED;
                        r_board_pause <= 1'b1;
                    end else if (w_start_edge) begin
                        r_state       <= S_PLAY;
                        r_ball_launch <= 1'b1;
                    end
                end

                S_PLAY: begin
                    // A cleared board beats a simultaneous miss: no life is lost.
                    if (bricks_cleared) begin
                        r_state     <= S_SERVE;
                        r_level     <= (r_level == 4'd15) ? r_level : r_level + 4'd1;
                        r_board_rst <= 1'b1;
                    end else if (ball_missed) begin
                        r_state       <= S_MISS;
                        r_lives       <= (r_lives == 3'd0) ? 3'd0 : r_lives - 3'd1;
                        r_miss_cnt    <= 26'd0;
                        r_board_pause <= 1'b1;
                    end else if (w_pause_edge) begin
                        r_saved       <= S_PLAY;
                        r_state       <= S_PAUSED;
                        r_board_pause <= 1'b1;
                    end
                end

                S_PAUSED: begin
                    if (w_pause_edge) begin
                        r_state       <= r_saved;
                        r_board_pause <= 1'b0;
                    end
                end

                S_MISS: begin
                    if (r_miss_cnt == MISS_LAST) begin
                        r_miss_cnt <= 26'd0;
                        if (r_lives == 3'd0) begin
                            r_state <= S_OVER;
                        end else begin
                            r_state       <= S_SERVE;
                            r_board_rst   <= 1'b1;
                            r_board_pause <= 1'b0;
                        end
                    end else begin
                        r_miss_cnt <= r_miss_cnt + 26'd1;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_board_pause <= 1'b1;
                end
            endcase
        end
    end

    assign board_rst   = r_board_rst;
    assign board_pause = r_board_pause;
    assign move_left   = r_move_left;
    assign move_right  = r_move_right;
    assign ball_launch = r_ball_launch;
    assign lives       = r_lives;
    assign level       = r_level;
    assign state       = r_state;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a game-rule model predicts every output pulse
// and a monitor pops and compares whenever the controller emits one.
module tb_game_ctrl;

    localparam int LI = 3;
    localparam int MD = 4;
    localparam int MH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_pause = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       ball_missed = 1'b0;
    logic       bricks_cleared = 1'b0;
    logic       board_rst;
    logic       board_pause;
    logic       move_left;
    logic       move_right;
    logic       ball_launch;
    logic [2:0] lives;
    logic [3:0] level;
    logic [2:0] state;

    always #5 clk = ~clk;

    game_ctrl #(.LIVES_INIT(LI), .MOVE_DIV(MD), .MISS_HOLD(MH)) dut (
        .clk(clk), .reset(reset),
        .btn_start(btn_start), .btn_pause(btn_pause),
        .btn_left(btn_left), .btn_right(btn_right),
        .ball_missed(ball_missed), .bricks_cleared(bricks_cleared),
        .board_rst(board_rst), .board_pause(board_pause),
        .move_left(move_left), .move_right(move_right),
        .ball_launch(ball_launch),
        .lives(lives), .level(level), .state(state)
    );

    typedef struct {
        int   cyc;
        logic rst;
        logic launch;
        logic ml;
        logic mr;
        int   st;
        int   lv;
        int   lev;
    } ev_t;

    ev_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_left = 0, cnt_right = 0, cnt_rst = 0, cnt_launch = 0, cnt_any = 0;

    // Game-rule model: state codes, lives, level, saved return state,
    // cycles spent live in SERVE/PLAY, and cycles left in MISS.
    int m_cyc = 0;
    int m_state = 0, m_lives = 0, m_level = 0, m_saved = 1, m_act = 0, m_miss_left = 0;
    bit m_ps = 0, m_pp = 0;

    task automatic model_step();
        bit se, pe, keep, rst, launch, ml, mr;
        ev_t e;
        m_cyc++;
        if (reset) begin
            m_state = 0; m_lives = 0; m_level = 0; m_saved = 1;
            m_act = 0; m_miss_left = 0; m_ps = 0; m_pp = 0;
            return;
        end
        se = btn_start && !m_ps;
        pe = btn_pause && !m_pp;
        m_ps = btn_start;
        m_pp = btn_pause;
        rst = 0; launch = 0; ml = 0; mr = 0;
        keep = (m_state == 1 && !pe) ||
               (m_state == 2 && !ball_missed && !bricks_cleared && !pe);
        if (keep) begin
            if (m_act % MD == MD - 1) begin
                ml = btn_left && !btn_right;
                mr = btn_right && !btn_left;
            end
            m_act++;
        end else begin
            m_act = 0;
        end
        case (m_state)
            0, 5: if (se) begin m_state = 1; m_lives = LI; m_level = 1; rst = 1; end
            1: begin
                if (pe) begin m_saved = 1; m_state = 3; end
                else if (se) begin m_state = 2; launch = 1; end
            end
            2: begin
                if (bricks_cleared) begin
                    m_state = 1; m_level = (m_level < 15) ? m_level + 1 : 15; rst = 1;
                end else if (ball_missed) begin
                    m_state = 4; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_miss_left = MH;
                end else if (pe) begin
                    m_saved = 2; m_state = 3;
                end
            end
            3: if (pe) m_state = m_saved;
            4: begin
                m_miss_left--;
                if (m_miss_left == 0) begin
                    if (m_lives == 0) m_state = 5;
                    else begin m_state = 1; rst = 1; end
                end
            end
            default: m_state = 0;
        endcase
        if (rst || launch || ml || mr) begin
            e.cyc = m_cyc; e.rst = rst; e.launch = launch; e.ml = ml; e.mr = mr;
            e.st = m_state; e.lv = m_lives; e.lev = m_level;
            sb_q.push_back(e);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    task automatic mon_step();
        ev_t e;
        if (board_rst || ball_launch || move_left || move_right) begin
            cnt_any++;
            if (move_left)   cnt_left++;
            if (move_right)  cnt_right++;
            if (board_rst)   cnt_rst++;
            if (ball_launch) cnt_launch++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_unexpected cyc=%0d got rst=%b launch=%b ml=%b mr=%b required no pulse",
                         m_cyc, board_rst, ball_launch, move_left, move_right);
            end else begin
                e = sb_q.pop_front();
                if (e.cyc != m_cyc || e.rst != board_rst || e.launch != ball_launch ||
                    e.ml != move_left || e.mr != move_right || e.st != int'(state) ||
                    e.lv != int'(lives) || e.lev != int'(level)) begin
                    n_fail++;
                    $display("FAIL pulse_event got cyc=%0d rst=%b launch=%b ml=%b mr=%b st=%0d lives=%0d lvl=%0d required cyc=%0d rst=%b launch=%b ml=%b mr=%b st=%0d lives=%0d lvl=%0d",
                             m_cyc, board_rst, ball_launch, move_left, move_right, state, lives, level,
                             e.cyc, e.rst, e.launch, e.ml, e.mr, e.st, e.lv, e.lev);
                end else begin
                    $display("event cyc=%0d rst=%b launch=%b ml=%b mr=%b st=%0d lives=%0d lvl=%0d ok",
                             m_cyc, board_rst, ball_launch, move_left, move_right, state, lives, level);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc <= m_cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL pulse_missing got no pulse at cyc=%0d required rst=%b launch=%b ml=%b mr=%b at cyc=%0d",
                     m_cyc, e.rst, e.launch, e.ml, e.mr, e.cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        mon_step();
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end else begin
            $display("check %s = %0d ok", name, got);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        btn_start = 1'b1; cyc(1); btn_start = 1'b0; cyc(1);
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; cyc(1); btn_pause = 1'b0; cyc(1);
    endtask

    task automatic chk_status(input string tag, input int st, input int lv, input int lev, input int bp);
        chk({tag, "_state"}, int'(state), st);
        chk({tag, "_lives"}, int'(lives), lv);
        chk({tag, "_level"}, int'(level), lev);
        chk({tag, "_pause"}, int'(board_pause), bp);
    endtask

    initial begin
        int c0, c1;
        // Reset state
        cyc(3);
        chk_status("reset", 0, 0, 0, 1);
        chk("reset_board_rst", int'(board_rst), 0);
        reset = 1'b0;
        cyc(2);

        // Start from IDLE
        press_start();
        chk_status("start", 1, 3, 1, 0);
        chk("start_rst_pulses", cnt_rst, 1);

        // Paddle stepping in SERVE
        c0 = cnt_left;
        btn_left = 1'b1; cyc(12); btn_left = 1'b0;
        chk("left_pulses", cnt_left - c0, 3);
        c0 = cnt_left; c1 = cnt_right;
        btn_left = 1'b1; btn_right = 1'b1; cyc(12);
        btn_left = 1'b0; btn_right = 1'b0;
        chk("both_pulses", (cnt_left - c0) + (cnt_right - c1), 0);

        // Serve, then pause/resume in PLAY
        c0 = cnt_launch;
        press_start();
        chk("serve_state", int'(state), 2);
        chk("launch_pulses", cnt_launch - c0, 1);
        btn_right = 1'b1;
        c1 = cnt_right;
        press_pause();
        chk_status("paused", 3, 3, 1, 1);
        cyc(10);
        chk("paused_moves", cnt_right - c1, 0);
        press_pause();
        chk_status("resumed", 2, 3, 1, 0);
        btn_right = 1'b0;

        // Simultaneous miss and clear
        ball_missed = 1'b1; bricks_cleared = 1'b1; cyc(1);
        ball_missed = 1'b0; bricks_cleared = 1'b0;
        chk_status("both_events", 1, 3, 2, 0);

        // Level saturation
        for (int i = 0; i < 15; i++) begin
            press_start();
            bricks_cleared = 1'b1; cyc(1); bricks_cleared = 1'b0;
        end
        chk_status("level_sat", 1, 3, 15, 0);

        // Lose all lives
        for (int k = 0; k < 3; k++) begin
            press_start();
            chk("miss_play_state", int'(state), 2);
            ball_missed = 1'b1; cyc(1); ball_missed = 1'b0;
            chk("miss_state", int'(state), 4);
            chk("miss_lives", int'(lives), 2 - k);
            cyc(MH + 2);
            chk("after_miss_state", int'(state), (k < 2) ? 1 : 5);
        end
        chk_status("game_over", 5, 0, 15, 1);

        // Restart, then reset while MISS hold counter is at 5
        press_start();
        chk_status("restart", 1, 3, 1, 0);
        press_start();
        ball_missed = 1'b1; cyc(1); ball_missed = 1'b0;
        cyc(5);
        reset = 1'b1;
        #1;
        chk_status("async_reset", 0, 0, 0, 1);
        cyc(1);
        chk("reset_hold_state", int'(state), 0);
        cyc(1);
        reset = 1'b0;
        c0 = cnt_any;
        cyc(6);
        chk("post_reset_pulses", cnt_any - c0, 0);
        chk_status("post_reset", 0, 0, 0, 1);

        // Randomized play against the model
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0)
                chk_status("rand", m_state, m_lives, m_level,
                           (m_state == 1 || m_state == 2) ? 0 : 1);
            if (i == 400) reset = 1'b1;
            if (i == 402) reset = 1'b0;
            btn_start      = ($urandom_range(0, 7) == 0);
            btn_pause      = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) btn_left  = ~btn_left;
            if ($urandom_range(0, 7) == 0) btn_right = ~btn_right;
            ball_missed    = ($urandom_range(0, 19) == 0);
            bricks_cleared = ($urandom_range(0, 24) == 0);
            cyc(1);
        end
        btn_start = 1'b0; btn_pause = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        ball_missed = 1'b0; bricks_cleared = 1'b0;
        cyc(20);
        chk_status("final", m_state, m_lives, m_level,
                   (m_state == 1 || m_state == 2) ? 0 : 1);
        chk("scoreboard_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
